// File: rtl/gray_pkg.sv
// Shared definitions for the gray-count readout blocks: sampler FSM state encoding
// and the default count width.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 8;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter; each binary bit is the XOR of all gray
// bits at or above it.
module gray_to_bin #(
    parameter int unsigned WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            bin[WIDTH-1-i] = bin[WIDTH-i] ^ gray[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/gray_count_sampler.sv
// Samples a gray count on strobe, converts to binary, computes the modular delta and
// holds {bin, delta} in a one-entry valid/ready buffer with sticky overrun.
// Optional saturating delta accumulator: define GRAY_SAMPLER_ACC_EN.
module gray_count_sampler
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             sample,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
`ifdef GRAY_SAMPLER_ACC_EN
    ,
    output logic [2*WIDTH-1:0] acc_out
`endif
);

    state_t           state;
    logic [WIDTH-1:0] gray_q;
    logic             sample_q;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] delta_c;
    logic             load_c;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray (gray_q),
        .bin  (bin_c)
    );

    always_comb begin
        delta_c = bin_c - prev_bin;
        // A registered sample is accepted unless it would overwrite an unconsumed result.
        load_c  = sample_q && ((state == S_EMPTY) || ready);
    end

    assign valid = (state == S_FULL);

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            gray_q    <= '0;
            sample_q  <= 1'b0;
            prev_bin  <= '0;
            bin_out   <= '0;
            delta_out <= '0;
            overrun   <= 1'b0;
            state     <= S_EMPTY;
        end else begin
            gray_q   <= gray_in;
            sample_q <= sample;

            if (clr_ovf) begin
                overrun <= 1'b0;
            end

            if (load_c) begin
                bin_out   <= bin_c;
                delta_out <= delta_c;
                prev_bin  <= bin_c;
                state     <= S_FULL;
            end else if (state == S_FULL) begin
                if (sample_q) begin
                    // Dropped sample: prev_bin is kept so the next delta spans the gap.
                    overrun <= 1'b1;
                end else if (ready) begin
                    state <= S_EMPTY;
                end
            end
        end
    end

`ifdef GRAY_SAMPLER_ACC_EN
    logic [2*WIDTH-1:0] acc_base;
    logic [2*WIDTH:0]   acc_sum;

    always_comb begin
        acc_base = clr_ovf ? '0 : acc_out;
        acc_sum  = {1'b0, acc_base} + {{(WIDTH+1){1'b0}}, delta_c};
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            acc_out <= '0;
        end else if (load_c) begin
            acc_out <= acc_sum[2*WIDTH] ? '1 : acc_sum[2*WIDTH-1:0];
        end else if (clr_ovf) begin
            acc_out <= '0;
        end
    end
`endif

endmodule

// File: doc/gray_count_sampler.md
Name: gray_count_sampler

Overview:
- Downstream consumer of the gray_sine_cell counter chain.
- On a sample strobe, captures the WIDTH-bit gray count, converts it to binary, and computes the modular delta since the last accepted sample.
- Presents {bin, delta} on a 1-entry valid/ready output buffer, with sticky overrun reporting.
- Feeds per-channel event-rate readout.

Parameters:
- WIDTH, 8, width of gray count input and of bin/delta outputs.

Ports:
- clk_master  in  1  single clock; all state updates on rising edge.
- rstb  in  1  asynchronous active-low reset.
- gray_in  in  WIDTH  gray count from the counter chain; bit j = q_j.
- sample  in  1  one-cycle capture strobe; may be asserted on consecutive cycles.
- clr_ovf  in  1  clears the overrun flag.
- bin_out  out  WIDTH  binary value of the captured count.
- delta_out  out  WIDTH  bin_out minus previous accepted bin, mod 2^WIDTH.
- valid  out  1  output buffer holds an unconsumed result.
- ready  in  1  consumer accepts the result when valid & ready.
- overrun  out  1  sticky; a sample was dropped because the buffer was full.

Behaviour:
- Reset (rstb low, async): gray_q=0, sample_q=0, prev_bin=0, bin_out=0, delta_out=0, valid=0, overrun=0, FSM=EMPTY.
- Stage 1, every edge: gray_q<=gray_in; sample_q<=sample.
  - gray_in is never used combinationally.
- Conversion: bin_c[WIDTH-1]=gray_q[WIDTH-1]; bin_c[i]=bin_c[i+1]^gray_q[i]. Delta: delta_c = bin_c - prev_bin, WIDTH-bit wraparound subtraction.
- Latency: sample high at edge N → valid high after edge N+1, i.e. 2 edges. gray_in value captured is the one present at edge N.
- First sample after reset: prev_bin=0, so delta_out = bin_out.
- FSM, states EMPTY and FULL:
  - EMPTY & sample_q: load bin_out/delta_out, prev_bin<=bin_c, go to FULL.
  - FULL & ready & !sample_q: go to EMPTY; outputs hold their last values.
  - FULL & ready & sample_q: load new result, stay FULL. The handshake and the reload coincide and valid stays 1.
  - FULL & !ready & sample_q: drop the sample and set overrun. prev_bin is NOT updated, so the next delta covers the full elapsed interval.
  - FULL & !ready & !sample_q: hold all outputs.
- valid = (FSM==FULL). bin_out and delta_out are stable while valid & !ready.
- overrun:
  - Set on a drop; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, the set wins.
- Reset mid-operation: an immediate return to reset values; any pending result is lost.

Optional Feature:
- Macro GRAY_SAMPLER_ACC_EN.
- Defined:
  - Adds output acc_out (2*WIDTH bits), reset 0.
  - acc_out += delta_c on every accepted load.
  - acc_out saturates at all-ones and does not wrap.
  - acc_out is cleared by clr_ovf; if clear and accumulate occur in the same cycle, the accumulate wins, so acc_out = delta_c.
- Undefined: no port and no logic; all other behaviour is identical.

Decomposition:
- Shared package/include gray_pkg holds:
  - localparams for the FSM state encoding, S_EMPTY=1'b0 and S_FULL=1'b1;
  - the default WIDTH constant.
- One combinational sub-module, gray_to_bin, parameterized by WIDTH. It is reused by other readout blocks.
- The FSM, datapath and overrun logic stay in gray_count_sampler.

Test Plan (WIDTH=4):
- Reset release, gray_in=4'b0010 (3), sample pulse, ready=1 → 2 edges later valid=1, bin_out=3, delta_out=3; deasserts after the handshake.
- Next sample with gray_in=4'b1101 (9) → bin_out=9, delta_out=6.
- Wrap: prev_bin=14 (gray 4'b1001), then gray_in=4'b0011 (2) → delta_out=4.
- ready=0 with FULL, second sample at gray 5 → overrun=1, outputs unchanged. Then ready=1 and a sample at gray 7 → delta relative to the last accepted bin. clr_ovf → overrun=0.
- sample held on 3 consecutive cycles with ready=1 and the count incrementing 4,5,6 → valid stays high, three results with delta 1 after the first.
- Assert rstb low while FULL → valid, overrun, bin_out and delta_out all 0 immediately, before the next edge.
